// File: rtl/kgp_dp_pkg.sv
// Shared types for the pipelined KGP-RISC datapath.
// ALU op encoding, EX control bundle and link register index.
package kgp_dp_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_XOR    = 4'd3,
    OP_COMP   = 4'd4,
    OP_SLA    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_PASS_B = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic wr_en;
    logic link;
    logic flag_we;
  } ex_ctl_t;

  // Link writes go to the all-ones register.
  function automatic int unsigned link_reg(
    input int unsigned aw
  );
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/kgp_alu_param.sv
// Combinational DATA_W ALU: result plus zero/carry/sign/overflow.
// Ports: i_op, i_a, i_b in; o_result, flags, o_op_valid out.
module kgp_alu_param
  import kgp_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_carry,
  output logic              o_sign,
  output logic              o_overflow,
  output logic              o_op_valid
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int M = DATA_W - 1;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [SH_W-1:0] w_sh;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SH_W-1:0];

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    o_op_valid = 1'b1;
    case (alu_op_e'(i_op))
      OP_ADD: begin
        o_result   = w_sum[M:0];
        o_carry    = w_sum[DATA_W];
        o_overflow = (i_a[M] == i_b[M]) &
                     (w_sum[M] != i_a[M]);
      end
      OP_SUB: begin
        o_result   = w_diff[M:0];
        o_carry    = w_diff[DATA_W];
        o_overflow = (i_a[M] != i_b[M]) &
                     (w_diff[M] != i_a[M]);
      end
      OP_AND:    o_result = i_a & i_b;
      OP_XOR:    o_result = i_a ^ i_b;
      OP_COMP:   o_result = -i_a;
      OP_SLA:    o_result = i_a << w_sh;
      OP_SRL:    o_result = i_a >> w_sh;
      OP_SRA:    o_result = DATA_W'($signed(i_a) >>> w_sh);
      OP_PASS_B: o_result = i_b;
      default:   o_op_valid = 1'b0;
    endcase
    o_zero = (o_result == '0);
    o_sign = o_result[M];
  end

endmodule

// File: rtl/pipelined_data_path.sv
// Three-stage (RD, EX, WB) KGP-RISC datapath with issue handshake.
// Ports: decoded fields + in_valid/in_ready in; wb_* and flags out.
module pipelined_data_path
  import kgp_dp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 10,
  parameter int IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       alu_op,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]      imm,
  input  logic                  use_imm,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  link,
  input  logic [DATA_W-1:0]     npc,
  input  logic                  flag_we,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  sign_flag,
  output logic                  overflow_flag
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int MDEP = 2 ** MEM_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] LINK_REG =
    REG_ADDR_W'(link_reg(REG_ADDR_W));

  logic [DATA_W-1:0] r_rf  [NREG];
  logic [DATA_W-1:0] r_mem [MDEP];

  logic                  r_ex_v;
  logic [OP_W-1:0]       r_ex_op;
  ex_ctl_t               r_ex_ctl;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic [DATA_W-1:0]     r_ex_a;
  logic [DATA_W-1:0]     r_ex_b;
  logic [DATA_W-1:0]     r_ex_sd;
  logic [DATA_W-1:0]     r_ex_npc;

  logic                  r_wb_v;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]     r_wb_res;
  logic                  r_wb_load;
  logic                  r_wb_link;
  logic [DATA_W-1:0]     r_wb_npc;
  logic [DATA_W-1:0]     r_wb_mdata;

  logic r_z, r_c, r_s, r_o;

  logic [DATA_W-1:0]     w_alu_res;
  logic                  w_alu_z, w_alu_c;
  logic                  w_alu_s, w_alu_o;
  logic                  w_op_ok;
  logic [DATA_W-1:0]     w_ex_wval;
  logic                  w_ex_fwd;
  logic                  w_ex_live;
  logic [DATA_W-1:0]     w_wb_data;
  logic [DATA_W-1:0]     w_rs1_d;
  logic [DATA_W-1:0]     w_rs2_d;
  logic [DATA_W-1:0]     w_imm_sx;
  logic                  w_uses_rs2;
  logic                  w_hazard;
  logic                  w_accept;
  logic [MEM_ADDR_W-1:0] w_maddr;

  kgp_alu_param #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op      (r_ex_op),
    .i_a       (r_ex_a),
    .i_b       (r_ex_b),
    .o_result  (w_alu_res),
    .o_zero    (w_alu_z),
    .o_carry   (w_alu_c),
    .o_sign    (w_alu_s),
    .o_overflow(w_alu_o),
    .o_op_valid(w_op_ok)
  );

  assign w_imm_sx  = DATA_W'($signed(imm));
  assign w_maddr   = MEM_ADDR_W'(w_alu_res);
  assign w_ex_live = r_ex_v & ~flush;
  assign w_ex_wval = r_ex_ctl.link ? r_ex_npc : w_alu_res;
  // Load data is not ready until WB, so EX only forwards non-loads.
  assign w_ex_fwd  = r_ex_v & r_ex_ctl.wr_en &
                     ~r_ex_ctl.mem_read & (r_ex_rd != '0);
  assign w_wb_data = r_wb_load ? r_wb_mdata :
                     r_wb_link ? r_wb_npc : r_wb_res;

  // Later assignments win: EX over WB over the bank.
  always_comb begin
    w_rs1_d = r_rf[rs1];
    w_rs2_d = r_rf[rs2];
    if (r_wb_v && r_wb_rd == rs1) w_rs1_d = w_wb_data;
    if (r_wb_v && r_wb_rd == rs2) w_rs2_d = w_wb_data;
    if (w_ex_fwd && r_ex_rd == rs1) w_rs1_d = w_ex_wval;
    if (w_ex_fwd && r_ex_rd == rs2) w_rs2_d = w_ex_wval;
  end

  assign w_uses_rs2 = ~use_imm | mem_write;
  assign w_hazard   = in_valid & r_ex_v & r_ex_ctl.mem_read &
                      ((r_ex_rd == rs1) |
                       (w_uses_rs2 & (r_ex_rd == rs2)));
  assign in_ready   = ~flush & ~w_hazard;
  assign w_accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v    <= 1'b0;
      r_ex_op   <= '0;
      r_ex_ctl  <= '0;
      r_ex_rd   <= '0;
      r_ex_a    <= '0;
      r_ex_b    <= '0;
      r_ex_sd   <= '0;
      r_ex_npc  <= '0;
      r_wb_v    <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_res  <= '0;
      r_wb_load <= 1'b0;
      r_wb_link <= 1'b0;
      r_wb_npc  <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_s       <= 1'b0;
      r_o       <= 1'b0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      r_ex_v <= w_accept;
      if (w_accept) begin
        r_ex_op           <= alu_op;
        r_ex_ctl.mem_read <= mem_read;
        r_ex_ctl.mem_write<= mem_write;
        r_ex_ctl.wr_en    <= reg_write | link;
        r_ex_ctl.link     <= link;
        r_ex_ctl.flag_we  <= flag_we;
        r_ex_rd           <= link ? LINK_REG : rd;
        r_ex_a            <= w_rs1_d;
        r_ex_b            <= use_imm ? w_imm_sx : w_rs2_d;
        r_ex_sd           <= w_rs2_d;
        r_ex_npc          <= npc;
      end
      r_wb_v <= w_ex_live & r_ex_ctl.wr_en &
                (r_ex_rd != '0);
      if (w_ex_live) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_res  <= w_alu_res;
        r_wb_load <= r_ex_ctl.mem_read;
        r_wb_link <= r_ex_ctl.link;
        r_wb_npc  <= r_ex_npc;
      end
      if (w_ex_live & r_ex_ctl.flag_we & w_op_ok) begin
        r_z <= w_alu_z;
        r_c <= w_alu_c;
        r_s <= w_alu_s;
        r_o <= w_alu_o;
      end
      if (r_wb_v) r_rf[r_wb_rd] <= w_wb_data;
    end
  end

  // Memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (!rst && w_ex_live) begin
      if (r_ex_ctl.mem_write) r_mem[w_maddr] <= r_ex_sd;
      if (r_ex_ctl.mem_read) r_wb_mdata <= r_mem[w_maddr];
    end
  end

  assign wb_valid      = r_wb_v;
  assign wb_addr       = r_wb_rd;
  assign wb_data       = w_wb_data;
  assign alu_result    = r_wb_res;
  assign zero_flag     = r_z;
  assign carry_flag    = r_c;
  assign sign_flag     = r_s;
  assign overflow_flag = r_o;

endmodule

// File: doc/pipelined_data_path.md
Name: pipelined_data_path

Overview:
Parametrised three-stage (RD, EX, WB) successor of the single-cycle KGP-RISC datapath, with a valid/ready issue handshake. It contains the register bank, ALU, data memory, operand forwarding, one-cycle load-use stall, branch flush and a link write. It sits between the control unit and instruction fetch; the control unit supplies decoded fields each cycle. Generalised over data width, register count and memory depth.

Parameters:
DATA_W, 32, datapath and register width (power of 2, >= 8)
REG_ADDR_W, 5, register address width; 2**REG_ADDR_W registers
MEM_ADDR_W, 10, data memory word-address width
IMM_W, 16, immediate width; sign-extended to DATA_W

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  datapath accepts this cycle; accept = in_valid & in_ready
alu_op  in  4  operation, encoding from package
rs1, rs2, rd  in  REG_ADDR_W each  source and destination registers
imm  in  IMM_W  immediate
use_imm  in  1  ALU B operand = sign-extended imm instead of rs2 data
mem_read, mem_write  in  1 each  load / store
reg_write  in  1  instruction writes rd
link  in  1  write npc to register all-ones (overrides rd and result)
npc  in  DATA_W  next PC value for link
flag_we  in  1  instruction updates flags
flush  in  1  kill RD-stage and EX-stage contents this cycle
wb_valid  out  1  register write occurring this cycle
wb_addr  out  REG_ADDR_W  register being written
wb_data  out  DATA_W  value being written
alu_result  out  DATA_W  registered EX result of the instruction now in WB
zero_flag, carry_flag, sign_flag, overflow_flag  out  1 each  registered flags

Behaviour:
- Reset: synchronous. On the rst edge, clear all stage valids, all registers to 0 and all flags to 0. Drive alu_result=0 and wb_valid=0 after reset. The reset edge writes no register and no memory; in-flight instructions are discarded. Memory contents are not cleared.
- Register 0 is hardwired to zero. Writes to register 0 are dropped, and wb_valid stays 0 for them.
- RD stage, on accept:
  - read rs1 and rs2 with forwarding. Priority: EX result (non-load only), then WB write data, then register bank.
  - capture operands, sign-extended imm and controls into RD registers.
- EX stage (the cycle after accept):
  - ALU computes combinationally.
  - memory address = result[MEM_ADDR_W-1:0].
  - a store writes the forwarded rs2 data at the end of EX.
  - a load issues a synchronous read; data returns in WB.
  - flags update at the end of EX only if flag_we.
- WB stage: wb_data = load data if mem_read, else npc if link, else the EX result. The register file is written at the end of WB.
- Latency: accept at cycle t → wb_valid at cycle t+2 → value readable from the register bank from t+3. A dependent instruction accepted at t+1 or t+2 gets the value via forwarding.
- Load-use hazard: the EX-stage instruction is a load and an incoming valid instruction reads its rd (rs1, or rs2 when !use_imm or mem_write).
  - in_ready=0 for exactly one cycle and a bubble is inserted.
  - otherwise in_ready=1.
- flush: clears RD and EX valid bits at the clock edge.
  - A flushed EX store does not write memory; a flushed instruction does not update flags.
  - The WB stage always completes.
  - Input is not accepted in a flush cycle.
  - flush and rst together: reset wins.
- ALU operations:
  - ADD and SUB: DATA_W-bit modulo. carry = carry-out; SUB carry = borrow.
  - overflow: signed overflow for ADD/SUB, 0 for other ops.
  - AND, XOR, COMP (two's complement of A), SLA, SRL, SRA, PASS_B.
  - shift amount = B[$clog2(DATA_W)-1:0].
  - zero = (result==0); sign = result MSB.
- Undefined alu_op codes: result 0, no flag change.

Decomposition:
- Package kgp_dp_pkg: the alu_op enum (ADD=0, SUB=1, AND=2, XOR=3, COMP=4, SLA=5, SRL=6, SRA=7, PASS_B=8), OP_W=4, and the link register index function (all-ones).
- One natural sub-module: kgp_alu_param, the combinational DATA_W ALU producing result and the four flags.
- The register bank and memory are inline arrays.

Test Plan:
- Reset mid-pipeline: issue ADD r1=5+7, assert rst the next cycle → wb_valid never 1, r1 reads 0, flags 0.
- Back-to-back dependency: ADD r2=r1+imm 3 (r1=10), then SUB r3=r2-r1 on the next cycle → wb_data 13 then 3, no stall.
- Load-use: SW r4=0xDEAD to addr 8, LW r5 from 8, then ADD r6=r5+1 → in_ready low one cycle, r6=0xDEAE.
- Flags at DATA_W=32: ADD 0x7FFFFFFF+1 with flag_we → overflow=1, sign=1, carry=0, zero=0. SUB 5-5 → zero=1.
- Flush: store issued, flush asserted while it is in EX → memory unchanged. The older instruction in WB still writes.
- Link and r0: link with npc=0x40 → register 31 = 0x40. ADD to r0 → wb_valid=0, r0 stays 0.
